// File: rtl/apb_reg_bank_if.sv
// APB3 bus bundle for the register bank: the master drives the request side
// and the slave returns read data and the completion/error handshake.
interface apb_reg_bank_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwdata, psel, penable, pwrite,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, psel, penable, pwrite,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_bank.sv
// APB3 slave register bank: CTRL (per-register write locks), NUM_REGS data
// registers with reset values and read-only masking, and a STATUS register
// exposing a saturating count of errored transfers. Each transfer is decoded
// once in SETUP; the result is held through the (optionally stretched)
// ACCESS phase and any write is committed on the pready edge.
module apb_reg_bank #(
  parameter int                         NUM_REGS    = 4,
  parameter int                         DATA_W      = 32,
  parameter int                         ADDR_W      = 32,
  parameter int                         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]        RO_MASK     = 4'b0001,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS    = {32'h0000_FFFF, 32'hA5A5_0000,
                                                       32'h1234_9876, 32'h5A5A_5555}
) (
  input  logic           pclk,
  input  logic           presetn,
  apb_reg_bank_if.slave  apb
);

  typedef enum logic {IDLE, ACCESS} state_e;

  // Word-address width, and the number of CTRL bits reachable through the bus.
  localparam int            AW          = ADDR_W - 2;
  localparam int            CW          = (NUM_REGS < DATA_W) ? NUM_REGS : DATA_W;
  localparam logic [3:0]    WS          = 4'(WAIT_STATES);
  localparam logic [AW-1:0] STATUS_WORD = AW'(NUM_REGS + 1);

  state_e                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;

  logic                  err_q;
  logic                  write_q;
  logic                  ctrlSel_q;
  logic                  statusSel_q;
  logic [NUM_REGS-1:0]   dataSel_q;
  logic [DATA_W-1:0]     prdata_q;

  logic [NUM_REGS-1:0]   ctrl_q;
  logic [DATA_W-1:0]     data_q [NUM_REGS];
  logic [15:0]           errCnt_q;

  logic [AW-1:0]         addrWord;
  logic                  aligned;
  logic                  ctrlHit;
  logic                  statusHit;
  logic [NUM_REGS-1:0]   dataHit;
  logic                  decodeErr;
  logic [DATA_W-1:0]     rdData;

  logic                  setup;
  logic                  pready;
  logic                  done;
  logic                  commitWr;
  logic                  errInc;

  // Phase qualifiers: a SETUP is only recognised from IDLE, so penable seen in
  // IDLE is ignored. A transfer completes only while psel is still held.
  assign setup    = (state_q == IDLE) && apb.psel && !apb.penable;
  assign pready   = (state_q == ACCESS) && (wcnt_q == WS);
  assign done     = pready && apb.psel;
  assign commitWr = done && write_q && !err_q;
  assign errInc   = done && err_q;

  assign apb.pready  = pready;
  assign apb.pslverr = pready && err_q;
  assign apb.prdata  = prdata_q;

  // Address decode, error classification and read-data mux for the SETUP cycle.
  always_comb begin
    addrWord  = apb.paddr[ADDR_W-1:2];
    aligned   = (apb.paddr[1:0] == 2'b00);
    ctrlHit   = aligned && (addrWord == '0);
    statusHit = aligned && (addrWord == STATUS_WORD);
    dataHit   = '0;
    rdData    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aligned && (addrWord == AW'(i + 1))) begin
        dataHit[i] = 1'b1;
        rdData     = data_q[i];
      end
    end
    if (ctrlHit) begin
      rdData = DATA_W'(ctrl_q[CW-1:0]);
    end
    if (statusHit) begin
      rdData = DATA_W'(errCnt_q);
    end
    decodeErr = !(ctrlHit || statusHit || (|dataHit)) ||
                (apb.pwrite && (|(dataHit & (RO_MASK | ctrl_q))));
  end

  // Next-state logic: leave ACCESS on completion or when psel is withdrawn.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          wcnt_d  = '0;
        end
      end
      ACCESS: begin
        if (!apb.psel || pready) begin
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and wait-state counter registers.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Capture the SETUP decode; read data is loaded now and held until the next read.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      ctrlSel_q   <= 1'b0;
      statusSel_q <= 1'b0;
      dataSel_q   <= '0;
      prdata_q    <= '0;
    end else if (setup) begin
      err_q       <= decodeErr;
      write_q     <= apb.pwrite;
      ctrlSel_q   <= ctrlHit;
      statusSel_q <= statusHit;
      dataSel_q   <= dataHit;
      if (!apb.pwrite) begin
        prdata_q <= decodeErr ? '0 : rdData;
      end
    end
  end

  // Register file: commit clean writes and count errored transfers at completion.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ctrl_q   <= '0;
      errCnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= RST_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      if (commitWr && ctrlSel_q) begin
        ctrl_q <= NUM_REGS'(apb.pwdata[CW-1:0]);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commitWr && dataSel_q[i] && !RO_MASK[i]) begin
          data_q[i] <= apb.pwdata;
        end
      end
      if (commitWr && statusSel_q) begin
        errCnt_q <= '0;
      end else if (errInc && (errCnt_q != 16'hFFFF)) begin
        errCnt_q <= errCnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank. Two instances share clock and reset:
// index 0 has no wait states, index 1 has three. A transaction-level model of
// the register map predicts read data, error response and transfer length.
module tb_apb_reg_bank;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
  } op_t;

  localparam logic [3:0] RO = 4'b0001;

  logic pclk;
  logic presetn;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mData [2][4];
  logic [3:0]  mCtrl [2];
  int          mErr  [2];
  logic [31:0] mRd   [2];

  apb_reg_bank_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  apb_reg_bank_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  apb_reg_bank #(
    .NUM_REGS(4), .DATA_W(32), .ADDR_W(32), .WAIT_STATES(0), .RO_MASK(4'b0001),
    .RST_VALS({32'h0000_FFFF, 32'hA5A5_0000, 32'h1234_9876, 32'h5A5A_5555})
  ) dut0 (
    .pclk(pclk), .presetn(presetn), .apb(bus0.slave)
  );

  apb_reg_bank #(
    .NUM_REGS(4), .DATA_W(32), .ADDR_W(32), .WAIT_STATES(3), .RO_MASK(4'b0001),
    .RST_VALS({32'h0000_FFFF, 32'hA5A5_0000, 32'h1234_9876, 32'h5A5A_5555})
  ) dut3 (
    .pclk(pclk), .presetn(presetn), .apb(bus3.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Hard stop in case anything stalls beyond the per-transfer bounds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input int d, input logic sel, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr; bus0.paddr = a; bus0.pwdata = wd;
    end else begin
      bus3.psel = sel; bus3.penable = en; bus3.pwrite = wr; bus3.paddr = a; bus3.pwdata = wd;
    end
  endtask

  function automatic logic getReady(input int d);
    return (d == 0) ? bus0.pready : bus3.pready;
  endfunction

  function automatic logic getErr(input int d);
    return (d == 0) ? bus0.pslverr : bus3.pslverr;
  endfunction

  function automatic logic [31:0] getRdata(input int d);
    return (d == 0) ? bus0.prdata : bus3.prdata;
  endfunction

  function automatic int expCycles(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // One complete APB transfer; cyc counts ACCESS cycles up to and including pready.
  task automatic busXfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int cyc);
    @(negedge pclk);
    drive(d, 1'b1, 1'b0, wr, a, wd);
    @(negedge pclk);
    drive(d, 1'b1, 1'b1, wr, a, wd);
    cyc = 1;
    while (!getReady(d) && cyc < 40) begin
      @(negedge pclk);
      cyc++;
    end
    rd  = getRdata(d);
    err = getErr(d);
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mData[d][0] = 32'h5A5A_5555;
      mData[d][1] = 32'h1234_9876;
      mData[d][2] = 32'hA5A5_0000;
      mData[d][3] = 32'h0000_FFFF;
      mCtrl[d]    = 4'h0;
      mErr[d]     = 0;
      mRd[d]      = 32'h0;
    end
  endtask

  // Register-map semantics at transaction level: word 0 CTRL, 1..4 DATA, 5 STATUS.
  task automatic modelXfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] expRd, output logic expErr);
    int  word;
    bit  err;
    err = (a[1:0] != 2'b00) || (a[31:2] > 30'd5);
    word = err ? -1 : int'(a[31:2]);
    if (!err && wr && word >= 1 && word <= 4) begin
      if (RO[word-1] || mCtrl[d][word-1]) err = 1'b1;
    end
    if (wr) begin
      if (!err) begin
        if (word == 0)      mCtrl[d] = wd[3:0];
        else if (word == 5) mErr[d] = 0;
        else                mData[d][word-1] = wd;
      end
    end else begin
      if (err)            mRd[d] = 32'h0;
      else if (word == 0) mRd[d] = {28'h0, mCtrl[d]};
      else if (word == 5) mRd[d] = 32'(mErr[d]);
      else                mRd[d] = mData[d][word-1];
    end
    if (err && mErr[d] < 65535) mErr[d] = mErr[d] + 1;
    expRd  = mRd[d];
    expErr = err;
  endtask

  task automatic test_reset();
    logic [31:0] rd, eRd;
    logic        err, eErr;
    int          cyc;
    logic [31:0] addrs [4];
    logic [31:0] vals  [4];
    addrs = '{32'h4, 32'h8, 32'hC, 32'h10};
    vals  = '{32'h5A5A_5555, 32'h1234_9876, 32'hA5A5_0000, 32'h0000_FFFF};
    @(negedge pclk);
    presetn = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (getReady(d) !== 1'b0 || getErr(d) !== 1'b0 || getRdata(d) !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d: pready=%b pslverr=%b prdata=%h, expected 0 0 00000000",
                 d, getReady(d), getErr(d), getRdata(d));
      end
    end
    presetn = 1'b1;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      busXfer(0, 1'b0, addrs[i], 32'h0, rd, err, cyc);
      modelXfer(0, 1'b0, addrs[i], 32'h0, eRd, eErr);
      checks++;
      if (rd !== vals[i] || rd !== eRd || err !== 1'b0 || cyc != 1) begin
        errors++;
        $display("[TB] FAIL reset_read %h: rd=%h err=%b cyc=%0d, expected rd=%h err=0 cyc=1",
                 addrs[i], rd, err, cyc, vals[i]);
      end
    end
  endtask

  task automatic test_write_readback();
    op_t ops[$];
    logic [31:0] rd, eRd;
    logic        err, eErr;
    int          cyc;
    ops.push_back('{1'b1, 32'h8,  32'hDEAD_BEEF});
    ops.push_back('{1'b0, 32'h8,  32'h0});
    ops.push_back('{1'b1, 32'h4,  32'h0BAD_0BAD});
    ops.push_back('{1'b0, 32'h4,  32'h0});
    ops.push_back('{1'b0, 32'h14, 32'h0});
    foreach (ops[i]) begin
      busXfer(0, ops[i].wr, ops[i].a, ops[i].wd, rd, err, cyc);
      modelXfer(0, ops[i].wr, ops[i].a, ops[i].wd, eRd, eErr);
      checks++;
      if (rd !== eRd || err !== eErr || cyc != 1) begin
        errors++;
        $display("[TB] FAIL write_readback op%0d a=%h: rd=%h err=%b cyc=%0d, expected rd=%h err=%b cyc=1",
                 i, ops[i].a, rd, err, cyc, eRd, eErr);
      end
    end
  endtask

  task automatic test_lock();
    op_t ops[$];
    logic [31:0] rd, eRd;
    logic        err, eErr;
    int          cyc;
    ops.push_back('{1'b1, 32'h0, 32'h0000_0004});
    ops.push_back('{1'b1, 32'hC, 32'h1111_1111});
    ops.push_back('{1'b0, 32'hC, 32'h0});
    ops.push_back('{1'b0, 32'h0, 32'h0});
    ops.push_back('{1'b1, 32'h0, 32'h0000_0000});
    ops.push_back('{1'b1, 32'hC, 32'h1111_1111});
    ops.push_back('{1'b0, 32'hC, 32'h0});
    foreach (ops[i]) begin
      busXfer(0, ops[i].wr, ops[i].a, ops[i].wd, rd, err, cyc);
      modelXfer(0, ops[i].wr, ops[i].a, ops[i].wd, eRd, eErr);
      checks++;
      if (rd !== eRd || err !== eErr || cyc != 1) begin
        errors++;
        $display("[TB] FAIL lock op%0d a=%h: rd=%h err=%b cyc=%0d, expected rd=%h err=%b cyc=1",
                 i, ops[i].a, rd, err, cyc, eRd, eErr);
      end
    end
  endtask

  task automatic test_addr_errors();
    op_t ops[$];
    logic [31:0] rd, eRd;
    logic        err, eErr;
    int          cyc;
    ops.push_back('{1'b0, 32'h40,        32'h0});
    ops.push_back('{1'b0, 32'h6,         32'h0});
    ops.push_back('{1'b0, 32'h14,        32'h0});
    ops.push_back('{1'b1, 32'h18,        32'h1234_5678});
    ops.push_back('{1'b1, 32'h8000_0008, 32'h1234_5678});
    ops.push_back('{1'b1, 32'h14,        32'hFFFF_FFFF});
    ops.push_back('{1'b0, 32'h14,        32'h0});
    foreach (ops[i]) begin
      busXfer(0, ops[i].wr, ops[i].a, ops[i].wd, rd, err, cyc);
      modelXfer(0, ops[i].wr, ops[i].a, ops[i].wd, eRd, eErr);
      checks++;
      if (rd !== eRd || err !== eErr || cyc != 1) begin
        errors++;
        $display("[TB] FAIL addr_errors op%0d a=%h: rd=%h err=%b cyc=%0d, expected rd=%h err=%b cyc=1",
                 i, ops[i].a, rd, err, cyc, eRd, eErr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, eRd;
    logic        err, eErr;
    int          cyc;
    for (int d = 0; d < 2; d++) begin
      busXfer(d, 1'b1, 32'h10, 32'hCAFE_F00D, rd, err, cyc);
      modelXfer(d, 1'b1, 32'h10, 32'hCAFE_F00D, eRd, eErr);
      busXfer(d, 1'b0, 32'h10, 32'h0, rd, err, cyc);
      modelXfer(d, 1'b0, 32'h10, 32'h0, eRd, eErr);
      checks++;
      if (rd !== eRd || err !== eErr || cyc != expCycles(d)) begin
        errors++;
        $display("[TB] FAIL back_to_back dut%0d: rd=%h err=%b cyc=%0d, expected rd=%h err=%b cyc=%0d",
                 d, rd, err, cyc, eRd, eErr, expCycles(d));
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, eRd;
    logic        err, eErr;
    int          cyc;
    int          seen;
    busXfer(1, 1'b0, 32'hC, 32'h0, rd, err, cyc);
    modelXfer(1, 1'b0, 32'hC, 32'h0, eRd, eErr);
    checks++;
    if (rd !== eRd || err !== eErr || cyc != 4) begin
      errors++;
      $display("[TB] FAIL wait_states_read: rd=%h err=%b cyc=%0d, expected rd=%h err=%b cyc=4",
               rd, err, cyc, eRd, eErr);
    end
    // Abort: one ACCESS cycle with psel held, then psel withdrawn.
    @(negedge pclk);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0BAD_F00D);
    @(negedge pclk);
    drive(1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0BAD_F00D);
    seen = int'(getReady(1));
    @(negedge pclk);
    seen += int'(getReady(1));
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (6) begin
      @(negedge pclk);
      seen += int'(getReady(1));
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_pready: pready high in %0d cycles, expected 0", seen);
    end
    busXfer(1, 1'b0, 32'h8, 32'h0, rd, err, cyc);
    modelXfer(1, 1'b0, 32'h8, 32'h0, eRd, eErr);
    checks++;
    if (rd !== eRd || err !== eErr || cyc != 4) begin
      errors++;
      $display("[TB] FAIL abort_no_write: rd=%h err=%b cyc=%0d, expected rd=%h err=%b cyc=4",
               rd, err, cyc, eRd, eErr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, eRd;
    logic        err, eErr;
    int          cyc;
    @(negedge pclk);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
    @(negedge pclk);
    drive(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
    @(negedge pclk);
    presetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      checks++;
      if (getReady(1) !== 1'b0 || getErr(1) !== 1'b0 || getRdata(1) !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_mid_outputs cycle%0d: pready=%b pslverr=%b prdata=%h, expected 0 0 00000000",
                 k, getReady(1), getErr(1), getRdata(1));
      end
    end
    presetn = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    modelReset();
    busXfer(1, 1'b0, 32'h10, 32'h0, rd, err, cyc);
    modelXfer(1, 1'b0, 32'h10, 32'h0, eRd, eErr);
    checks++;
    if (rd !== 32'h0000_FFFF || rd !== eRd || err !== 1'b0 || cyc != 4) begin
      errors++;
      $display("[TB] FAIL reset_mid_read: rd=%h err=%b cyc=%0d, expected rd=0000ffff err=0 cyc=4",
               rd, err, cyc);
    end
    busXfer(0, 1'b0, 32'h14, 32'h0, rd, err, cyc);
    modelXfer(0, 1'b0, 32'h14, 32'h0, eRd, eErr);
    checks++;
    if (rd !== eRd || err !== eErr || cyc != 1) begin
      errors++;
      $display("[TB] FAIL reset_mid_status: rd=%h err=%b cyc=%0d, expected rd=%h err=%b cyc=1",
               rd, err, cyc, eRd, eErr);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, eRd, a, wd;
    logic        err, eErr, wr;
    int          cyc, d, sel;
    for (int n = 0; n < 300; n++) begin
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      case (sel)
        0, 1, 2, 3, 4, 5: a = 32'(sel * 4);
        6:                a = 32'h18;
        7:                a = 32'($urandom_range(0, 5) * 4 + $urandom_range(1, 3));
        8:                a = 32'h40;
        default:          a = $urandom;
      endcase
      busXfer(d, wr, a, wd, rd, err, cyc);
      modelXfer(d, wr, a, wd, eRd, eErr);
      checks++;
      if (rd !== eRd || err !== eErr || cyc != expCycles(d)) begin
        errors++;
        $display("[TB] FAIL random#%0d dut%0d wr=%b a=%h: rd=%h err=%b cyc=%0d, expected rd=%h err=%b cyc=%0d",
                 n, d, wr, a, rd, err, cyc, eRd, eErr, expCycles(d));
      end
    end
  endtask

  initial begin
    presetn = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    modelReset();
    test_reset();
    test_write_readback();
    test_lock();
    test_addr_errors();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

Parametrised APB3 slave register bank: a control/lock register, NUM_REGS data registers with per-register reset values and read-only masking, and a status register carrying a saturating error counter. Adds configurable wait states, PREADY/PSLVERR signalling, per-register write locking and address/alignment checking. Sits on the peripheral APB bus as the register front-end for datapath blocks; it is the next generation of the team's fixed four-register APB bank.

## Interface
- NUM_REGS, 4: number of data registers, 1..28.
- DATA_W, 32: register and bus data width, 16..32.
- ADDR_W, 32: paddr width.
- WAIT_STATES, 0: ACCESS cycles inserted before pready, 0..15.
- RO_MASK, 4'b0001 (NUM_REGS bits): bit i set makes data register i read-only.
- RST_VALS, {32'h0000_FFFF, 32'hA5A5_0000, 32'h1234_9876, 32'h5A5A_5555} (NUM_REGS*DATA_W bits): reset value of data register i in slice i.
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  reset, synchronous, active-low.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- prdata  out  DATA_W  read data; reset 0.
- pready  out  1  transfer complete; reset 0.
- pslverr  out  1  transfer error, valid only with pready; reset 0.

## Operation
- Map (word-aligned): 0x0 CTRL; 0x4*(i+1) DATA[i], i = 0..NUM_REGS-1; 0x4*(NUM_REGS+1) STATUS. Everything else unmapped.
- CTRL: NUM_REGS bits, RW, zero-extended on read. CTRL[i]=1 locks DATA[i] against writes. Reset 0.
- DATA[i]: RW unless RO_MASK[i]; reset to RST_VALS slice i.
- STATUS: read = {zeros, err_cnt[15:0]}. Any write clears err_cnt to 0 (legal, no error).
- FSM, states IDLE and ACCESS, reset IDLE. IDLE -> ACCESS when psel=1, penable=0 (SETUP); IDLE otherwise. ACCESS -> IDLE on the cycle pready=1. psel dropping in ACCESS aborts to IDLE, no side effects, no pready.
- On SETUP, register: address decode, error flag, read data. Error if: unmapped, paddr[1:0]!=0, write to RO DATA[i], write to DATA[i] with CTRL[i]=1. Reads of RO or locked registers are legal.
- Read data is loaded into prdata on SETUP (0 on error) and held until the next read SETUP; writes leave prdata unchanged.
- Write commit: at the pready=1 edge, only if no error. Errored transfers change no register.
- err_cnt increments by 1 at the pready=1 edge of each errored transfer, saturating at 16'hFFFF. Errored write to STATUS is impossible (STATUS is always writable).
- penable=1 seen in IDLE (protocol violation) is ignored.

## Timing
- wcnt counts ACCESS cycles, cleared on entering ACCESS. pready = (state==ACCESS) & (wcnt==WAIT_STATES), combinational from registers only.
- Transfer length: 2 + WAIT_STATES cycles (SETUP + ACCESS). WAIT_STATES=0: pready high in the first ACCESS cycle.
- pslverr = pready & registered error flag; 0 whenever pready=0.
- Back-to-back: next SETUP may follow the pready cycle directly; no idle cycle required.
- Register write visible to a read whose SETUP is the cycle after the write's pready cycle.
- Reset low on any edge: state IDLE, wcnt 0, pready/pslverr/prdata 0, CTRL 0, DATA to RST_VALS, err_cnt 0; in-flight transfer discarded, no commit.

## Test plan
- Reset then read 0x4, 0x8, 0xC, 0x10 -> prdata 5A5A5555, 12349876, A5A50000, 0000FFFF, pslverr 0, pready in 2nd cycle (WAIT_STATES=0).
- Write 0xDEADBEEF to 0x8, read back -> DEADBEEF; write 0x4 -> pslverr 1, read 0x4 still 5A5A5555, STATUS reads 1.
- Write CTRL=0x4, write 0x11111111 to 0xC -> pslverr 1, 0xC unchanged; CTRL=0, retry -> written, pslverr 0.
- Read 0x40 and 0x6 -> pslverr 1, prdata 0; STATUS = prior+2; write STATUS -> reads 0.
- WAIT_STATES=3: pready exactly 4 cycles after SETUP (5-cycle transfer); psel drop after 1 ACCESS cycle -> no write, no pready.
- Reset asserted mid ACCESS of a write to 0x10 -> 0x10 reads 0000FFFF, pready 0 during reset, next transfer normal.
